// File: rtl/bank_fifo_pkg.sv
// Shared defaults, FSM encoding and index-width helper for the bank FIFO reader.
package bank_fifo_pkg;

  localparam int W_DEF          = 16;
  localparam int BANK_WORDS_DEF = 128;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  function automatic int idx_w(input int words);
    return (words < 2) ? 1 : $clog2(words);
  endfunction

  localparam int IDX_W_DEF = idx_w(BANK_WORDS_DEF);

endpackage

// File: rtl/bank_fifo_seq_check.sv
// Incrementing-sequence checker: the first loaded word becomes the reference, each later word must be previous+1.
// Combinational mismatch/expected against the current data; state updates on load.
module bank_fifo_seq_check
  import bank_fifo_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] data,
  output logic         mismatch,
  output logic [W-1:0] expected
);

  logic [W-1:0] prev;
  logic         first;

  assign expected = prev + W'(1);
  assign mismatch = !first && (data != expected);

  always_ff @(posedge clk) begin
    if (rst) begin
      prev  <= '0;
      first <= 1'b1;
    end else if (load) begin
      prev  <= data;
      first <= 1'b0;
    end
  end

endmodule

// File: rtl/bank_fifo_drain.sv
// Bank FIFO reader: trigger/done reads forwarded to a one-word valid/ready slot, per-bank word counting.
// Sequence checking is present only when BANK_FIFO_DRAIN_SEQ_CHECK_EN is defined; otherwise err* are tied to 0.
module bank_fifo_drain
  import bank_fifo_pkg::*;
#(
  parameter int W          = W_DEF,
  parameter int BANK_WORDS = BANK_WORDS_DEF,
  parameter int BANK_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  r_trigger,
  input  logic [W-1:0]          r_data,
  input  logic                  r_done,
  output logic [W-1:0]          out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  bank_done,
  output logic [BANK_CNT_W-1:0] bank_cnt,
  output logic                  err,
  output logic [W-1:0]          err_expected,
  output logic [W-1:0]          err_got
);

  localparam int            IW       = idx_w(BANK_WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(BANK_WORDS - 1);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [IW-1:0] idx;
  logic          xfer;
  logic          mismatch;
  logic          slot_free_nxt;
  logic          last_word;

  assign xfer      = r_trigger && r_done;
  assign last_word = (idx == LAST_IDX);

  // The trigger is registered, so a read may only be requested when the slot
  // is guaranteed empty on the cycle the request is live: nothing arriving now
  // and the current word (if any) leaving now.
  assign slot_free_nxt = !xfer && (!out_valid || out_ready);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (en) state_nxt = ST_RUN;
      ST_RUN: begin
        if (xfer && mismatch) state_nxt = ST_ERR;
        else if (!en)         state_nxt = ST_IDLE;
      end
      ST_ERR:  state_nxt = ST_ERR;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      r_trigger <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      bank_done <= 1'b0;
      bank_cnt  <= '0;
      idx       <= '0;
    end else begin
      state     <= state_nxt;
      r_trigger <= (state_nxt == ST_RUN) && en && slot_free_nxt;
      out_valid <= xfer || (out_valid && !out_ready);
      bank_done <= xfer && last_word;
      if (xfer) begin
        out_data <= r_data;
        idx      <= last_word ? '0 : idx + 1'b1;
        if (last_word) bank_cnt <= bank_cnt + 1'b1;
      end
    end
  end

`ifdef BANK_FIFO_DRAIN_SEQ_CHECK_EN
  logic [W-1:0] expected;

  bank_fifo_seq_check #(.W(W)) u_seq_check (
    .clk      (clk),
    .rst      (rst),
    .load     (xfer),
    .data     (r_data),
    .mismatch (mismatch),
    .expected (expected)
  );

  // Only the first mismatch is recorded; later ones cannot occur because
  // the trigger is dropped once the FSM reaches ERR.
  always_ff @(posedge clk) begin
    if (rst) begin
      err          <= 1'b0;
      err_expected <= '0;
      err_got      <= '0;
    end else if (xfer && mismatch && !err) begin
      err          <= 1'b1;
      err_expected <= expected;
      err_got      <= r_data;
    end
  end
`else
  assign mismatch     = 1'b0;
  assign err          = 1'b0;
  assign err_expected = '0;
  assign err_got      = '0;
`endif

endmodule

// File: tb/tb_bank_fifo_drain.sv
// Directed bench for bank_fifo_drain: FIFO model, output scoreboard, sequence-check vector table.
module tb_bank_fifo_drain;

`ifdef BANK_FIFO_DRAIN_SEQ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        en;
  logic        r_trigger;
  logic [15:0] r_data;
  logic        r_done;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        bank_done;
  logic [15:0] bank_cnt;
  logic        err;
  logic [15:0] err_expected;
  logic [15:0] err_got;

  bank_fifo_drain #(.W(16), .BANK_WORDS(128), .BANK_CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .r_trigger    (r_trigger),
    .r_data       (r_data),
    .r_done       (r_done),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .bank_done    (bank_done),
    .bank_cnt     (bank_cnt),
    .err          (err),
    .err_expected (err_expected),
    .err_got      (err_got)
  );

  typedef struct {
    logic [3:0][15:0] w;
    int               n;
    int               n_fwd;
    logic             err;
    logic [15:0]      e_exp;
    logic [15:0]      e_got;
  } seq_vec_t;

  logic [15:0] fq[$];
  logic [15:0] exp_q[$];
  logic [15:0] bd_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_acc = 0;
  int          rdy_mode = 0;
  bit          fifo_en = 0;
  bit          pend_pop = 0;
  bit          chk_slot = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FIFO model and out_ready driver, updated just after each rising edge.
  always @(posedge clk) begin
    logic [15:0] tmp;
    #1;
    if (pend_pop && fq.size() > 0) tmp = fq.pop_front();
    r_done = fifo_en && (fq.size() > 0);
    r_data = (fq.size() > 0) ? fq[0] : 16'h0000;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor/scoreboard on the falling edge: predicts the coming transfer and checks accepted words.
  always @(negedge clk) begin
    if (rst) begin
      pend_pop = 1'b0;
    end else begin
      pend_pop = r_trigger && r_done;
      if (pend_pop) check("overrun", {63'd0, out_valid && !out_ready}, 64'd0);
      if (chk_slot && out_valid && !out_ready) check("trigger_while_full", {63'd0, r_trigger}, 64'd0);
      if (bank_done) begin
        check("bank_done_with_valid", {63'd0, out_valid}, 64'd1);
        bd_q.push_back(out_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_word: got %0h expected none", out_data);
        end else begin
          check("word", {48'd0, out_data}, {48'd0, exp_q.pop_front()});
        end
        n_acc++;
      end
    end
  end

  task automatic push_word(input logic [15:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1; en = 1'b0; fifo_en = 1'b0; chk_slot = 1'b0; rdy_mode = 0;
    fq.delete(); exp_q.delete(); bd_q.delete(); n_acc = 0;
    @(posedge clk);
    @(negedge clk);
    check("rst_ctl", {60'd0, r_trigger, out_valid, bank_done, err}, 64'd0);
    check("rst_data", {16'd0, out_data, err_expected, err_got}, 64'd0);
    check("rst_bank_cnt", {48'd0, bank_cnt}, 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic wait_acc(input int n, input int budget);
    int c = 0;
    while ((n_acc < n || out_valid) && c < budget) begin
      @(posedge clk); #2;
      c++;
    end
    check("accepted_count", 64'(n_acc), 64'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    seq_vec_t tv[5];
    tv[0] = '{w: {16'h0001, 16'h0000, 16'hFFFF, 16'hFFFE}, n: 4, n_fwd: 4,
              err: 1'b0, e_exp: 16'h0, e_got: 16'h0};
    tv[1] = '{w: {16'h0009, 16'h0008, 16'h0006, 16'h0005}, n: 4, n_fwd: CHK ? 3 : 4,
              err: CHK, e_exp: CHK ? 16'h0007 : 16'h0, e_got: CHK ? 16'h0008 : 16'h0};
    tv[2] = '{w: {16'h0000, 16'h1235, 16'h1235, 16'h1234}, n: 3, n_fwd: 3,
              err: CHK, e_exp: CHK ? 16'h1236 : 16'h0, e_got: CHK ? 16'h1235 : 16'h0};
    tv[3] = '{w: {16'h0000, 16'h0000, 16'h8000, 16'h0000}, n: 2, n_fwd: 2,
              err: CHK, e_exp: CHK ? 16'h0001 : 16'h0, e_got: CHK ? 16'h8000 : 16'h0};
    tv[4] = '{w: {16'h8002, 16'h8001, 16'h8000, 16'h7FFF}, n: 4, n_fwd: 4,
              err: 1'b0, e_exp: 16'h0, e_got: 16'h0};

    rst = 1'b1; en = 1'b0; r_done = 1'b0; r_data = 16'h0; out_ready = 1'b1;

    // Two full banks, continuous FIFO, always-ready sink.
    do_reset();
    for (int i = 0; i < 256; i++) push_word(16'(i));
    en = 1'b1; fifo_en = 1'b1;
    wait_acc(256, 2000);
    check("t1_bank_done_count", 64'(bd_q.size()), 64'd2);
    check("t1_bank_done_0", {48'd0, bd_q[0]}, 64'h007F);
    check("t1_bank_done_1", {48'd0, bd_q[1]}, 64'h00FF);
    check("t1_bank_cnt", {48'd0, bank_cnt}, 64'd2);
    check("t1_err", {63'd0, err}, 64'd0);

    // Toggling out_ready: order preserved, no request while the slot is stuck.
    do_reset();
    for (int i = 0; i < 40; i++) push_word(16'(16'h0400 + i));
    rdy_mode = 1; chk_slot = 1'b1;
    en = 1'b1; fifo_en = 1'b1;
    wait_acc(40, 1000);
    chk_slot = 1'b0;
    check("t2_bank_cnt", {48'd0, bank_cnt}, 64'd0);

    // Sequence-check vectors.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      for (int k = 0; k < tv[v].n; k++) push_word(tv[v].w[k]);
      en = 1'b1; fifo_en = 1'b1;
      wait_acc(tv[v].n_fwd, 200);
      repeat (5) begin @(posedge clk); #2; end
      check($sformatf("v%0d_no_extra", v), 64'(n_acc), 64'(tv[v].n_fwd));
      check($sformatf("v%0d_err", v), {63'd0, err}, {63'd0, tv[v].err});
      check($sformatf("v%0d_err_expected", v), {48'd0, err_expected}, {48'd0, tv[v].e_exp});
      check($sformatf("v%0d_err_got", v), {48'd0, err_got}, {48'd0, tv[v].e_got});
      check($sformatf("v%0d_trigger_after", v), {63'd0, r_trigger}, {63'd0, !tv[v].err});
    end

    // en dropped mid-bank: bank position is kept across the pause.
    do_reset();
    for (int i = 0; i < 140; i++) push_word(16'(i));
    en = 1'b1; fifo_en = 1'b1;
    for (int c = 0; c < 400 && n_acc < 60; c++) begin @(posedge clk); #2; end
    en = 1'b0;
    repeat (10) begin @(posedge clk); #2; end
    check("t5_paused_trigger", {62'd0, r_trigger, out_valid}, 64'd0);
    en = 1'b1;
    wait_acc(140, 1000);
    check("t5_bank_done_count", 64'(bd_q.size()), 64'd1);
    check("t5_bank_done_word", {48'd0, bd_q[0]}, 64'h007F);
    check("t5_bank_cnt", {48'd0, bank_cnt}, 64'd1);

    // Reset while a word is held, then a fresh bank with a new reference.
    do_reset();
    for (int i = 0; i < 100; i++) push_word(16'(i));
    rdy_mode = 2;
    en = 1'b1; fifo_en = 1'b1;
    for (int c = 0; c < 20 && !out_valid; c++) begin @(posedge clk); #2; end
    check("t6_held_valid", {63'd0, out_valid}, 64'd1);
    do_reset();
    for (int i = 0; i < 128; i++) push_word(16'(16'h0300 + i));
    en = 1'b1; fifo_en = 1'b1;
    wait_acc(128, 1000);
    check("t6_bank_done_count", 64'(bd_q.size()), 64'd1);
    check("t6_bank_done_word", {48'd0, bd_q[0]}, 64'h037F);
    check("t6_bank_cnt", {48'd0, bank_cnt}, 64'd1);
    check("t6_err", {63'd0, err}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
